xpb_table_gen: RTL and testbench
================================

# xpb_table_gen

Run-time generator for the XPB reduction tables used by the modular squaring pipeline. It replaces a hard-coded constant ROM with a writer that computes `entry[i] = i * 2^SHIFT mod N` for every `i` in `0 .. 2^IDX_BITS-1`. Each entry is streamed to a table RAM over a simple write port, so one bitstream serves any modulus loaded at start-up. One instance fills one segment table; the squarer reads the RAM with the same 5-bit index and 1024-bit data shape as the fixed tables.

## Interface
Parameters:
- `WIDTH`, 1024: modulus and entry width in bits.
- `IDX_BITS`, 5: table index width; the table holds `2^IDX_BITS` entries.
- `SHIFT`, 460: bit position of the segment; legal range is 1 or more.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to generate a table; accepted only in IDLE.
- `modulus`  in  WIDTH: N. It is sampled on the accepted `start` cycle and must satisfy N odd and N > 1.
- `busy`  out  1: high from the cycle after an accepted `start` through the last write.
- `done`  out  1: one-cycle pulse after the last write.
- `wr_en`  out  1: RAM write strobe.
- `wr_addr`  out  IDX_BITS: RAM write index.
- `wr_data`  out  WIDTH: entry value, always in the range `0 .. N-1`.

## Operation
- FSM states: IDLE, BASE, FILL, DONE.
- IDLE:
  - On `start`, latch N into `n_q`, set `r = 1`, set `cnt = 0`, and go to BASE.
  - `start` in any other state is ignored.
- BASE runs exactly SHIFT cycles.
  - Each cycle: `r = (2r >= N) ? 2r - N : 2r`.
  - The compare uses a WIDTH+1-bit intermediate.
  - After the last cycle `r = 2^SHIFT mod N`; that value is held in `base_q`. Go to FILL with `acc = 0` and `idx = 0`.
- FILL runs exactly `2^IDX_BITS` cycles.
  - Each cycle: `wr_en = 1`, `wr_addr = idx`, `wr_data = acc`.
  - Then update `acc = (acc + base_q >= N) ? acc + base_q - N : acc + base_q` and `idx = idx + 1`.
  - After writing index `2^IDX_BITS - 1`, go to DONE; the `idx` wrap to 0 is not written.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Arithmetic rule: every operand is already reduced (less than N), so a single conditional subtract suffices. No multiplier is used.
- Reset mid-operation: every state returns to IDLE immediately, all outputs go to 0, and no further writes occur. RAM contents written so far are left as they are.
- `modulus` changing while `busy` has no effect, because only `n_q` is used.

## Timing
- Reset values: `busy = 0`, `done = 0`, `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`.
- All outputs are registered.
- Cycle schedule, with `start` sampled at cycle 0:
  - BASE occupies cycles 1 .. SHIFT.
  - Entry `i` is written at cycle `SHIFT + 1 + i`.
  - `done` is high at cycle `SHIFT + 1 + 2^IDX_BITS`.
  - `busy` is high over cycles 1 .. `SHIFT + 2^IDX_BITS`.
- Total latency is `SHIFT + 2^IDX_BITS + 1` cycles, which is 493 cycles at the default parameters.
- `wr_en` is a continuous burst of `2^IDX_BITS` cycles with no gaps. The RAM must accept one write per cycle.
- `start` is accepted in IDLE only, so `start` coincident with `done` is ignored. A new `start` is accepted from the following cycle.

## Structure
- Shared package `xpb_gen_pkg` holds the FSM state enum (IDLE, BASE, FILL, DONE) and the default `WIDTH`, `IDX_BITS` and `SHIFT` constants.
- Sub-module `mod_add_sub`, combinational: computes `(a + b) mod N` for inputs `a, b < N` in WIDTH+1-bit arithmetic.
  - A single instance is shared between the two phases.
  - In BASE: `a = b = r`.
  - In FILL: `a = acc`, `b = base_q`.
- Registers in the top level: `n_q`, `r`/`acc` (one shared register), `base_q`, the BASE cycle counter (`$clog2(SHIFT+1)` bits), `idx`, and the state register.

## Test plan
- WIDTH=8, N=251, SHIFT=8: `2^8 mod 251 = 5`. Required response: 32 writes with entry i equal to 5i, entry 31 = 155, write 0 at cycle 9, `done` at cycle 41.
- WIDTH=8, N=13, SHIFT=4: base is 3, which exercises the reduction in every phase. Required response: entry 4 = 12, entry 5 = 2, entry 31 = 2, and every entry is below 13.
- WIDTH=16, N=0xFFF1, SHIFT=16: base is 15. Required response: entry 31 = 465 (0x1D1), and the `busy` window is exactly 48 cycles.
- Default parameters with a 1024-bit odd modulus: compare all 32 entries against a bignum golden model, and check `done` at cycle 493.
- Reset and start handling:
  - Assert `rst_n` low at FILL index 10. Required response: outputs drop to 0 asynchronously and no writes follow.
  - A fresh `start` after reset produces a complete, correct table.
- `start` pulsed at cycles 5 and 200 during BASE/FILL, with `modulus` changed at the same times: both pulses are ignored and the table matches the modulus latched at cycle 0.

Source files
------------

// File: rtl/xpb_table_gen_pkg.sv
// Shared definitions for the XPB table generator: FSM states and default sizing.
package xpb_gen_pkg;

  localparam int DEF_WIDTH    = 1024;
  localparam int DEF_IDX_BITS = 5;
  localparam int DEF_SHIFT    = 460;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xpb_table_gen_if.sv
// Control and RAM write port of the XPB table generator, plus FSM state for observation.
interface xpb_table_gen_if
  import xpb_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IDX_BITS = DEF_IDX_BITS
) ();

  // start is a one-cycle request taken only while the FSM is IDLE (no ready; requests
  // at other times are dropped). wr_en is a push-only strobe: the RAM must take every
  // write on the cycle it is presented, with wr_addr/wr_data valid only while wr_en=1.
  logic                start;
  logic [WIDTH-1:0]    modulus;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  state_t              state;

  modport master (
    output start, modulus,
    input  busy, done, wr_en, wr_addr, wr_data, state
  );

  modport slave (
    input  start, modulus,
    output busy, done, wr_en, wr_addr, wr_data, state
  );

endinterface

// File: rtl/xpb_table_gen_mod_add_sub.sv
// Modular add with a single conditional subtract; both inputs must already be below n_i.
module mod_add_sub #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH:0] sum_raw;
  logic [WIDTH:0] n_ext;

  always_comb begin
    n_ext   = {1'b0, n_i};
    sum_raw = {1'b0, a_i} + {1'b0, b_i};
    sum_o   = (sum_raw >= n_ext) ? WIDTH'(sum_raw - n_ext) : sum_raw[WIDTH-1:0];
  end

endmodule

// File: rtl/xpb_table_gen.sv
// Computes entry[i] = i * 2^SHIFT mod N by repeated doubling, then repeated addition,
// streaming one entry per cycle to a table RAM.
module xpb_table_gen
  import xpb_gen_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  xpb_table_gen_if.slave bus
);

  localparam int CNT_W = $clog2(SHIFT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SHIFT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    n_q, n_d;
  logic [WIDTH-1:0]    r_q, r_d;        // doubling residue in BASE, accumulator in FILL
  logic [WIDTH-1:0]    base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [WIDTH-1:0]    add_b;
  logic [WIDTH-1:0]    sum;

  // One adder serves both phases: r+r while doubling, acc+base while filling.
  assign add_b = (state_q == FILL) ? base_q : r_q;

  mod_add_sub #(.WIDTH(WIDTH)) u_mod_add_sub (
    .a_i  (r_q),
    .b_i  (add_b),
    .n_i  (n_q),
    .sum_o(sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      r_q       <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      r_q       <= r_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    r_d       = r_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.modulus;
          r_d     = WIDTH'(1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = BASE;
        end
      end
      BASE: begin
        r_d   = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Entry 0 is always zero, so it goes out on the same edge the base is captured.
          base_d  = sum;
          r_d     = '0;
          idx_d   = '0;
          wr_en_d = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (idx_q == IDX_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          r_d       = sum;
          idx_d     = idx_q + 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q + 1'b1;
          wr_data_d = sum;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: four parameter sets, golden tables from wide-integer arithmetic.
module tb_xpb_table_gen;
  import xpb_gen_pkg::*;

  localparam int NI = 4;
  localparam int P_W[NI] = '{8, 8, 16, 1024};
  localparam int P_S[NI] = '{8, 4, 16, 460};

  typedef struct {
    int             g;
    logic [1023:0]  n;
    int             idx;
    logic [1023:0]  val;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start_a;
  logic [1023:0] mod_a [NI];
  logic [NI-1:0] busy_a, done_a, wr_en_a;
  logic [4:0]    addr_a [NI];
  logic [1023:0] data_a [NI];
  logic [1023:0] got_tab [32];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < NI; g++) begin : gi
    xpb_table_gen_if #(.WIDTH(P_W[g]), .IDX_BITS(5)) bus ();
    assign bus.start   = start_a[g];
    assign bus.modulus = mod_a[g][P_W[g]-1:0];
    assign busy_a[g]   = bus.busy;
    assign done_a[g]   = bus.done;
    assign wr_en_a[g]  = bus.wr_en;
    assign addr_a[g]   = bus.wr_addr;
    assign data_a[g]   = 1024'(bus.wr_data);

    xpb_table_gen #(.WIDTH(P_W[g]), .IDX_BITS(5), .SHIFT(P_S[g])) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [1023:0] ref_entry(input int s, input logic [1023:0] n, input int i);
    logic [2047:0] nn;
    logic [2047:0] b;
    nn = {1024'b0, n};
    b  = (2048'(1) << s) % nn;
    b  = (b * 2048'(i)) % nn;
    return b[1023:0];
  endfunction

  function automatic logic [1023:0] rand_mod(input int g);
    logic [1023:0] m;
    logic [1023:0] mask;
    for (int k = 0; k < 32; k++) m[k*32 +: 32] = $urandom;
    mask = (P_W[g] == 1024) ? '1 : ((1024'(1) << P_W[g]) - 1);
    m = m & mask;
    m[0] = 1'b1;
    if (m < 3) m = 3;
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got_lo=%0h exp_lo=%0h diff_bits=%0d", name, got[127:0], exp[127:0],
               $countones(got ^ exp));
    end
  endtask

  // mode: 0 plain, 1 start/modulus disturbed at cycles 5 and 200,
  //       2 reset asserted when index 10 is written, 3 start coincident with done
  task automatic run_table(input int g, input logic [1023:0] n, input int mode);
    logic [1023:0] exp_q[$];
    int s, rel, nwr, busy_bad, wr_bad, done_at, done_cnt, first_wr, rst_rel;
    bit in_rst;
    s = P_S[g];
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(ref_entry(s, n, i));
      got_tab[i] = '0;
    end
    nwr = 0; busy_bad = 0; wr_bad = 0; done_at = -1; done_cnt = 0; first_wr = -1;
    in_rst = 1'b0; rst_rel = 0;
    @(negedge clk);
    start_a[g] = 1'b1;
    mod_a[g]   = n;
    rel = 0;
    while (rel < s + 40) begin
      @(negedge clk);
      rel++;
      start_a[g] = (mode == 1 && (rel == 5 || rel == 200)) || (mode == 3 && rel == s + 33);
      if (mode == 1 && (rel == 5 || rel == 200)) mod_a[g] = rand_mod(g);
      if (in_rst && rel == rst_rel + 3) rst_n = 1'b1;
      if (busy_a[g] !== (rel >= 1 && rel <= s + 32)) busy_bad++;
      if (done_a[g]) begin
        done_cnt++;
        if (done_at < 0) done_at = rel;
      end
      if (wr_en_a[g]) begin
        if (first_wr < 0) first_wr = rel;
        if (addr_a[g] !== 5'(rel - s - 1)) wr_bad++;
        if (data_a[g] >= n) wr_bad++;
        got_tab[addr_a[g]] = data_a[g];
        nwr++;
        if (exp_q.size() == 0) wr_bad++;
        else check("entry", data_a[g], exp_q.pop_front());
        if (mode == 2 && !in_rst && addr_a[g] == 5'd10) begin
          rst_n = 1'b0;
          #1;
          check("rst_async_ctl", {busy_a[g], done_a[g], wr_en_a[g], addr_a[g]}, '0);
          check("rst_async_data", data_a[g], '0);
          in_rst = 1'b1;
          rst_rel = rel;
        end
      end
    end
    if (mode == 2) begin
      check("rst_writes", nwr, 11);
      check("rst_done", done_cnt, 0);
    end else begin
      check("writes", nwr, 32);
      check("first_wr_cycle", first_wr, s + 1);
      check("done_cycle", done_at, s + 33);
      check("done_pulses", done_cnt, 1);
      check("busy_window", busy_bad, 0);
    end
    check("wr_addr_range", wr_bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[9];
    int last_g;
    logic [1023:0] last_n, m;
    vecs[0] = '{0, 1024'd251, 0, 1024'd0};
    vecs[1] = '{0, 1024'd251, 1, 1024'd5};
    vecs[2] = '{0, 1024'd251, 31, 1024'd155};
    vecs[3] = '{1, 1024'd13, 4, 1024'd12};
    vecs[4] = '{1, 1024'd13, 5, 1024'd2};
    vecs[5] = '{1, 1024'd13, 31, 1024'd2};
    vecs[6] = '{1, 1024'd13, 1, 1024'd3};
    vecs[7] = '{2, 1024'hFFF1, 31, 1024'd465};
    vecs[8] = '{2, 1024'hFFF1, 1, 1024'd15};

    start_a = '0;
    foreach (mod_a[i]) mod_a[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset_ctl", {busy_a[g], done_a[g], wr_en_a[g], addr_a[g]}, '0);
      check("reset_data", data_a[g], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven spot values from hand-derived tables.
    last_g = -1;
    last_n = '0;
    foreach (vecs[v]) begin
      if (vecs[v].g != last_g || vecs[v].n != last_n) begin
        run_table(vecs[v].g, vecs[v].n, 0);
        last_g = vecs[v].g;
        last_n = vecs[v].n;
      end
      check($sformatf("vec%0d", v), got_tab[vecs[v].idx], vecs[v].val);
    end

    // Full-width tables, start/modulus disturbance, reset mid-fill, restart.
    run_table(3, rand_mod(3), 0);
    run_table(3, rand_mod(3), 1);
    m = rand_mod(3);
    run_table(3, m, 2);
    run_table(3, m, 0);
    run_table(0, 1024'd251, 3);
    run_table(0, 1024'd251, 0);
    check("restart_entry31", got_tab[31], 1024'd155);

    for (int k = 0; k < 4; k++) begin
      int g;
      g = $urandom_range(0, 2);
      run_table(g, rand_mod(g), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
